// File: rtl/max_exp_stream.sv
// Streaming max-exponent finder: per-beat lane reduction, then a running max over i_last-delimited groups.
// Optional MAX_EXP_STREAM_SPECIAL_EN excludes all-ones exponents from the max and reports them on o_special.
module max_exp_stream #(
   parameter int unsigned EXP_W  = 6,
   parameter int unsigned LANES  = 9,
   parameter int unsigned BEAT_W = 8,
   localparam int unsigned IDX_W = $clog2(LANES)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic [LANES*EXP_W-1:0] i_exp,
   input  logic [LANES-1:0]       i_skip,
   input  logic                   i_last,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [EXP_W-1:0]       o_max_exp,
   output logic [IDX_W-1:0]       o_max_idx,
   output logic [BEAT_W-1:0]      o_max_beat,
   output logic [BEAT_W-1:0]      o_beats,
   output logic                   o_empty,
   output logic                   o_special
);

   typedef enum logic {ST_FIRST, ST_ACCUM} grp_t;

   logic              en;
   logic [EXP_W-1:0]  lane_v, beat_max;
   logic [IDX_W-1:0]  beat_idx;
   logic              lane_use, beat_live;
   logic              a_valid, a_last, a_live;
   logic [EXP_W-1:0]  a_max;
   logic [IDX_W-1:0]  a_idx;
   grp_t              state, state_nxt;
   logic [EXP_W-1:0]  run_max, nxt_max;
   logic [IDX_W-1:0]  run_idx, nxt_idx;
   logic [BEAT_W-1:0] run_beat, nxt_beat, beat_cnt, nxt_cnt;
   logic              seen_live, nxt_live, take, first;
`ifdef MAX_EXP_STREAM_SPECIAL_EN
   logic              beat_special, a_special, run_special, nxt_special;
`endif

   assign en      = ~o_valid | i_ready;
   assign o_ready = en;

   // Strict '>' scan from zero keeps the lowest lane among equal maxima.
   always_comb begin
      lane_v    = '0;
      lane_use  = 1'b0;
      beat_max  = '0;
      beat_idx  = '0;
      beat_live = 1'b0;
`ifdef MAX_EXP_STREAM_SPECIAL_EN
      beat_special = 1'b0;
`endif
      for (int unsigned k = 0; k < LANES; k++) begin
         lane_v   = i_exp[k*EXP_W +: EXP_W];
         lane_use = ~i_skip[k];
`ifdef MAX_EXP_STREAM_SPECIAL_EN
         if (lane_use && (lane_v == '1)) begin
            beat_special = 1'b1;
            lane_use     = 1'b0;
         end
`endif
         if (!lane_use)
            lane_v = '0;
         beat_live = beat_live | lane_use;
         if (lane_v > beat_max) begin
            beat_max = lane_v;
            beat_idx = IDX_W'(k);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_valid <= 1'b0;
         a_last  <= 1'b0;
         a_live  <= 1'b0;
         a_max   <= '0;
         a_idx   <= '0;
`ifdef MAX_EXP_STREAM_SPECIAL_EN
         a_special <= 1'b0;
`endif
      end else if (en) begin
         a_valid <= i_valid;
         a_last  <= i_last;
         a_live  <= beat_live;
         a_max   <= beat_max;
         a_idx   <= beat_idx;
`ifdef MAX_EXP_STREAM_SPECIAL_EN
         a_special <= beat_special;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= ST_FIRST;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (en && a_valid)
         state_nxt = a_last ? ST_FIRST : ST_ACCUM;
   end

   // A live beat also wins when nothing live has been seen, so an all-skipped
   // leading beat never blocks a later live maximum of 0.
   always_comb begin
      first    = (state == ST_FIRST);
      take     = first | (a_live & (~seen_live | (a_max > run_max)));
      nxt_max  = take ? a_max : run_max;
      nxt_idx  = take ? a_idx : run_idx;
      nxt_beat = first ? '0 : (take ? beat_cnt : run_beat);
      nxt_cnt  = first ? BEAT_W'(1) :
                 ((beat_cnt == '1) ? beat_cnt : beat_cnt + BEAT_W'(1));
      nxt_live = first ? a_live : (seen_live | a_live);
`ifdef MAX_EXP_STREAM_SPECIAL_EN
      nxt_special = first ? a_special : (run_special | a_special);
`endif
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_max   <= '0;
         run_idx   <= '0;
         run_beat  <= '0;
         beat_cnt  <= '0;
         seen_live <= 1'b0;
`ifdef MAX_EXP_STREAM_SPECIAL_EN
         run_special <= 1'b0;
`endif
      end else if (en && a_valid) begin
         run_max   <= nxt_max;
         run_idx   <= nxt_idx;
         run_beat  <= nxt_beat;
         beat_cnt  <= nxt_cnt;
         seen_live <= nxt_live;
`ifdef MAX_EXP_STREAM_SPECIAL_EN
         run_special <= nxt_special;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid    <= 1'b0;
         o_max_exp  <= '0;
         o_max_idx  <= '0;
         o_max_beat <= '0;
         o_beats    <= '0;
         o_empty    <= 1'b0;
      end else if (en) begin
         o_valid <= a_valid & a_last;
         if (a_valid && a_last) begin
            o_max_exp  <= nxt_max;
            o_max_idx  <= nxt_idx;
            o_max_beat <= nxt_beat;
            o_beats    <= nxt_cnt;
            o_empty    <= ~nxt_live;
         end
      end
   end

`ifdef MAX_EXP_STREAM_SPECIAL_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_special <= 1'b0;
      else if (en && a_valid && a_last)
         o_special <= nxt_special;
   end
`else
   assign o_special = 1'b0;
`endif

endmodule

// File: tb/tb_max_exp_stream.sv
// Directed bench for max_exp_stream: group-level reference model with per-cycle output checks
// plus literal expectations for each scenario.
module tb_max_exp_stream;
   localparam int EXP_W  = 6;
   localparam int LANES  = 9;
   localparam int BEAT_W = 8;
   localparam int IDX_W  = 4;
   localparam int CNT_MAX = (1 << BEAT_W) - 1;

   logic clk = 1'b0, rst_n = 1'b0;
   logic i_valid = 1'b0, i_last = 1'b0, i_ready = 1'b1;
   logic [LANES*EXP_W-1:0] i_exp = '0;
   logic [LANES-1:0] i_skip = '0;
   logic o_ready, o_valid, o_empty, o_special;
   logic [EXP_W-1:0] o_max_exp;
   logic [IDX_W-1:0] o_max_idx;
   logic [BEAT_W-1:0] o_max_beat, o_beats;

   max_exp_stream #(.EXP_W(EXP_W), .LANES(LANES), .BEAT_W(BEAT_W)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_exp(i_exp), .i_skip(i_skip), .i_last(i_last), .o_valid(o_valid),
      .i_ready(i_ready), .o_max_exp(o_max_exp), .o_max_idx(o_max_idx),
      .o_max_beat(o_max_beat), .o_beats(o_beats), .o_empty(o_empty),
      .o_special(o_special)
   );

   always #5 clk = ~clk;

   typedef struct {int bm; int bi; bit live; bit sp;} beat_t;
   typedef struct {int mx; int idx; int bt; int nb; bit emp; bit sp;} res_t;

   beat_t grp[$];
   res_t  expq[$];
   res_t  res[64];
   int    res_cyc[64];
   int    nres = 0;
   int    checks = 0, errors = 0;
   int    cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [LANES*EXP_W-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      int v[LANES];
      logic [LANES*EXP_W-1:0] r;
      v = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      r = '0;
      for (int k = 0; k < LANES; k++) r[k*EXP_W +: EXP_W] = v[k][EXP_W-1:0];
      return r;
   endfunction

   // Beat-level reference: maximum over unskipped lane values, lowest lane attaining it.
   function automatic beat_t reduce(input logic [LANES*EXP_W-1:0] e, input logic [LANES-1:0] s);
      beat_t b;
      int v[LANES];
      b = '{0, 0, 1'b0, 1'b0};
      for (int k = 0; k < LANES; k++) begin
         int x;
         bit use_l;
         x = int'(e[k*EXP_W +: EXP_W]);
         use_l = !s[k];
`ifdef MAX_EXP_STREAM_SPECIAL_EN
         if (use_l && x == (1 << EXP_W) - 1) begin
            b.sp = 1'b1;
            use_l = 1'b0;
         end
`endif
         v[k] = use_l ? x : 0;
         if (use_l) b.live = 1'b1;
      end
      for (int k = 0; k < LANES; k++) if (v[k] > b.bm) b.bm = v[k];
      for (int k = LANES - 1; k >= 0; k--) if (v[k] == b.bm) b.bi = k;
      return b;
   endfunction

   // Group result: earliest live beat holding the largest live beat max.
   function automatic res_t close_group();
      res_t r;
      r.nb  = (grp.size() > CNT_MAX) ? CNT_MAX : grp.size();
      r.emp = 1'b1;
      r.sp  = 1'b0;
      r.mx  = grp[0].bm;
      r.idx = grp[0].bi;
      r.bt  = 0;
      foreach (grp[j]) begin
         r.sp = r.sp | grp[j].sp;
         if (grp[j].live && (r.emp || grp[j].bm > r.mx)) begin
            r.emp = 1'b0;
            r.mx  = grp[j].bm;
            r.idx = grp[j].bi;
            r.bt  = (j > CNT_MAX) ? CNT_MAX : j;
         end
      end
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Inputs change only just after posedge, so negedge sees the values the next edge will use.
   always @(negedge clk) begin
      res_t e;
      if (!rst_n) begin
         grp.delete();
         expq.delete();
      end else begin
         if (o_valid) begin
            if (expq.size() == 0) begin
               chk("spurious_valid", 32'd1, 32'd0);
            end else begin
               e = expq[0];
               chk("max_exp", o_max_exp, e.mx);
               chk("max_idx", o_max_idx, e.idx);
               chk("max_beat", o_max_beat, e.bt);
               chk("beats", o_beats, e.nb);
               chk("empty", o_empty, e.emp);
               chk("special", o_special, e.sp);
               if (i_ready) begin
                  void'(expq.pop_front());
                  res[nres % 64] = '{int'(o_max_exp), int'(o_max_idx), int'(o_max_beat),
                                     int'(o_beats), o_empty, o_special};
                  res_cyc[nres % 64] = cyc;
                  nres++;
               end
            end
         end
         if (i_valid && o_ready) begin
            grp.push_back(reduce(i_exp, i_skip));
            if (i_last) begin
               expq.push_back(close_group());
               grp.delete();
            end
         end
      end
   end

   task automatic send(input logic [LANES*EXP_W-1:0] e, input logic [LANES-1:0] s, input logic l);
      int n;
      n = 0;
      i_valid = 1'b1; i_exp = e; i_skip = s; i_last = l;
      forever begin
         @(negedge clk);
         if (o_ready) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk); #1;
      i_valid = 1'b0; i_last = 1'b0;
   endtask

   task automatic wait_res(input int target);
      int n;
      n = 0;
      while (nres < target && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (nres < target) chk("result_timeout", nres, target);
      @(posedge clk); #1;
   endtask

   task automatic sat_group(input int hot, input int val);
      for (int j = 0; j < 260; j++)
         send((j == hot) ? pk(0, 0, val, 0, 0, 0, 0, 0, 0) : pk(1, 0, 0, 0, 0, 0, 0, 0, 0),
              '0, j == 259);
   endtask

   initial begin
      int b;
      logic [LANES*EXP_W-1:0] t1;
      t1 = pk(3, 17, 9, 17, 0, 5, 22, 1, 4);

      rst_n = 1'b0; i_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", o_valid, 0);
      chk("rst_max_exp", o_max_exp, 0);
      chk("rst_max_idx", o_max_idx, 0);
      chk("rst_max_beat", o_max_beat, 0);
      chk("rst_beats", o_beats, 0);
      chk("rst_empty", o_empty, 0);
      chk("rst_special", o_special, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", o_ready, 1);
      @(posedge clk); #1;

      // single beat, two-cycle latency
      b = nres;
      send(t1, '0, 1'b1);
      @(negedge clk); chk("lat_cycle1", o_valid, 0);
      @(negedge clk); chk("lat_cycle2", o_valid, 1);
      wait_res(b + 1);
      chk("t1_max", res[b].mx, 22);
      chk("t1_idx", res[b].idx, 6);
      chk("t1_beat", res[b].bt, 0);
      chk("t1_beats", res[b].nb, 1);
      chk("t1_empty", res[b].emp, 0);

      // skip the winner: tie between lanes 1 and 3
      b = nres;
      send(t1, 9'b0_0100_0000, 1'b1);
      wait_res(b + 1);
      chk("t2_max", res[b].mx, 17);
      chk("t2_idx", res[b].idx, 1);

      // three-beat group, earlier beat wins the tie
      b = nres;
      send(pk(1, 2, 10, 3, 4, 5, 6, 7, 8), '0, 1'b0);
      send(pk(0, 0, 0, 0, 0, 12, 0, 0, 0), '0, 1'b0);
      send(pk(12, 1, 1, 1, 1, 1, 1, 1, 1), '0, 1'b1);
      wait_res(b + 1);
      chk("t3_max", res[b].mx, 12);
      chk("t3_idx", res[b].idx, 5);
      chk("t3_beat", res[b].bt, 1);
      chk("t3_beats", res[b].nb, 3);

      // all-skipped groups followed by a live group, back to back
      b = nres;
      send(pk(5, 6, 7, 8, 9, 10, 11, 12, 13), '1, 1'b0);
      send(pk(30, 6, 7, 8, 9, 10, 11, 12, 13), '1, 1'b1);
      send(pk(5, 40, 7, 8, 9, 10, 11, 12, 13), '1, 1'b1);
      send(t1, '0, 1'b1);
      wait_res(b + 3);
      chk("t4a_empty", res[b].emp, 1);
      chk("t4a_max", res[b].mx, 0);
      chk("t4a_beats", res[b].nb, 2);
      chk("t4b_empty", res[b+1].emp, 1);
      chk("t4b_max", res[b+1].mx, 0);
      chk("t4c_max", res[b+2].mx, 22);
      chk("t4c_empty", res[b+2].emp, 0);
      chk("t4_gap_ab", res_cyc[b+1] - res_cyc[b], 1);
      chk("t4_gap_bc", res_cyc[b+2] - res_cyc[b+1], 1);

      // backpressure: result held, input stalled, next result one cycle after release
      i_ready = 1'b0;
      send(t1, '0, 1'b1);
      send(pk(7, 7, 30, 1, 1, 1, 1, 1, 1), '0, 1'b1);
      repeat (4) begin
         @(negedge clk);
         chk("t5_ready_low", o_ready, 0);
         chk("t5_hold_valid", o_valid, 1);
         chk("t5_hold_max", o_max_exp, 22);
      end
      @(posedge clk); #1 i_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("t5_next_valid", o_valid, 1);
      chk("t5_next_max", o_max_exp, 30);
      chk("t5_next_idx", o_max_idx, 2);
      @(posedge clk); #1;

      // reset mid-group discards the partial group
      send(pk(40, 0, 0, 0, 0, 0, 0, 0, 0), '0, 1'b0);
      send(pk(0, 41, 0, 0, 0, 0, 0, 0, 0), '0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_valid", o_valid, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      b = nres;
      send(pk(0, 0, 0, 7, 2, 0, 0, 0, 0), '0, 1'b1);
      wait_res(b + 1);
      chk("t6_beats", res[b].nb, 1);
      chk("t6_max", res[b].mx, 7);

      // all-ones exponent on lane 3
      b = nres;
      send(pk(1, 2, 3, 63, 20, 5, 6, 7, 8), '0, 1'b1);
      wait_res(b + 1);
`ifdef MAX_EXP_STREAM_SPECIAL_EN
      chk("t7_special", res[b].sp, 1);
      chk("t7_max", res[b].mx, 20);
      chk("t7_idx", res[b].idx, 4);
`else
      chk("t7_special", res[b].sp, 0);
      chk("t7_max", res[b].mx, 63);
      chk("t7_idx", res[b].idx, 3);
`endif

      // beat counter saturation
      b = nres;
      sat_group(3, 9);
      sat_group(257, 11);
      wait_res(b + 2);
      chk("t8a_beats", res[b].nb, 255);
      chk("t8a_beat", res[b].bt, 3);
      chk("t8a_max", res[b].mx, 9);
      chk("t8b_beats", res[b+1].nb, 255);
      chk("t8b_beat", res[b+1].bt, 255);
      chk("t8b_max", res[b+1].mx, 11);

      repeat (20) begin
         if (expq.size() == 0) break;
         @(negedge clk);
      end
      chk("drain", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/max_exp_stream.md
Name: max_exp_stream

Overview:
- Streaming, pipelined max-exponent finder for the MAC subsystem's block-floating-point alignment path.
- Each accepted beat carries LANES exponents plus a per-lane skip mask. The block reduces each beat to its maximum, then keeps a running maximum across a group of beats closed by i_last.
- Per group it emits the maximum exponent, the lane and beat where it first occurred, the beat count and an all-skipped flag.
- It sits between the operand fetch stage and the significand alignment shifters, and replaces the fixed 9-lane combinational max tree.

Parameters:
- EXP_W, 6, exponent width in bits (unsigned, biased).
- LANES, 9, lanes per beat; LANES >= 2.
- BEAT_W, 8, width of the beat counter and beat-index outputs.
- Derived localparam IDX_W = $clog2(LANES).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept a beat this cycle.
- i_exp  input  LANES*EXP_W  lane k exponent at bits [k*EXP_W +: EXP_W].
- i_skip  input  LANES  bit k = 1 excludes lane k.
- i_last  input  1  the beat is the final beat of its group.
- o_valid  output  1  group result valid.
- i_ready  input  1  downstream accepts the result.
- o_max_exp  output  EXP_W  group maximum exponent.
- o_max_idx  output  IDX_W  lane of the first occurrence of the maximum.
- o_max_beat  output  BEAT_W  beat (0-based, within the group) of the first occurrence.
- o_beats  output  BEAT_W  beats in the group, saturating.
- o_empty  output  1  every lane of every beat in the group was skipped.
- o_special  output  1  an all-ones exponent was seen in the group (macro only).

Behaviour:
- Reset (asynchronous, i_rst_n = 0):
  - All registers clear.
  - o_valid = 0, o_max_exp = 0, o_max_idx = 0, o_max_beat = 0, o_beats = 0, o_empty = 0, o_special = 0.
  - Pipeline valids and the accumulator clear; a group in flight is discarded.
  - o_ready = 1 from the first cycle after release.
- Global enable:
  - en = ~o_valid | i_ready; o_ready = en.
  - A beat is accepted when i_valid & o_ready.
  - When en = 0, all stages hold.
- Stage A (registered on en):
  - Skipped lanes are masked to 0.
  - Reduction tree yields the beat max and its lowest lane index among equal maxima.
  - Also registered: any_live (at least one unskipped lane), last, a_valid.
  - An all-skipped beat gives beat max 0, idx 0, any_live = 0.
- Stage B accumulator (updates when en & a_valid):
  - Fields: run_max, run_idx, run_beat, beat_cnt, seen_live.
  - The first beat of a group loads unconditionally.
  - A later beat replaces the stored max only if any_live and beat_max > run_max (strictly greater), so earlier beats win ties.
  - A live beat also replaces when seen_live = 0.
  - beat_cnt increments, saturating at 2^BEAT_W - 1; o_max_beat uses the pre-increment value.
- Output register:
  - Loads when en & a_valid & a_last.
  - o_beats = updated count; o_empty = ~seen_live after this beat.
  - The accumulator returns to the first-beat state in the same cycle.
  - Back-to-back groups have no bubble.
- Latency:
  - A last beat accepted at cycle t gives o_valid at t+2 with no backpressure.
  - Throughput is 1 beat/cycle.
  - o_valid stays high with outputs stable until i_ready.
- Single-beat groups (i_last on every beat) are legal.
- i_valid = 0 cycles inside a group are bubbles and do not count as beats.
- A comparison only ever selects an existing lane value, so no width growth occurs.

Optional Feature:
- Macro MAX_EXP_STREAM_SPECIAL_EN.
- Defined:
  - A lane whose exponent is all ones (Inf/NaN) is treated as skipped for the max.
  - Stage A registers a per-beat special flag; it is OR-accumulated over the group and presented on o_special.
- Undefined:
  - All-ones exponents compete normally.
  - o_special is tied 0 and no special-flag logic exists.

Test Plan:
- Single beat, exps lane0..8 = 3,17,9,17,0,5,22,1,4, skip = 0, last = 1 -> after 2 cycles: o_max_exp = 22, o_max_idx = 6, o_max_beat = 0, o_beats = 1, o_empty = 0.
- Same beat with skip[6] = 1 -> o_max_exp = 17, o_max_idx = 1 (lowest tie index).
- 3-beat group with beat maxima 10 (lane 2), 12 (lane 5), 12 (lane 0); last on beat 2 -> o_max_exp = 12, o_max_idx = 5, o_max_beat = 1, o_beats = 3.
- Two groups with all skip = 1'b1 on every beat -> o_empty = 1, o_max_exp = 0; the next live group reports normally with no bubble.
- Result pending with i_ready held 0 for 4 cycles -> o_ready = 0, outputs stable; i_ready = 1 -> next result after 1 cycle.
- Reset asserted mid-group after 2 beats, then a 1-beat group of max 7 -> o_beats = 1, o_max_exp = 7.
- With the macro defined, lane 3 = 63 and the rest <= 20 -> o_special = 1, o_max_exp = 20.
